// File: rtl/mmu_memory_controller.sv
// Single-request memory controller with a direct-mapped TLB and a two-word page-table walk on miss.
// Define TLB_STATS_EN to add the saturating tlbHitCount/tlbMissCount outputs.
module mmu_memory_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int PAGE_BITS   = 12,
  parameter int TLB_ENTRIES = 64,
  parameter int PH_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mcReadReq,
  input  logic                  mcWriteReq,
  input  logic                  mcAddrVirtual,
  input  logic                  mcExecMode,
  input  logic [ADDR_WIDTH-1:0] mcRamAddress,
  input  logic [DATA_WIDTH-1:0] mcRamIn,
  output logic [DATA_WIDTH-1:0] mcRamOut,
  output logic [1:0]            mcStatus,
  output logic [1:0]            mcFault,
  input  logic                  tlbFlush,
  input  logic [ADDR_WIDTH-1:0] ptAddress,
  output logic [ADDR_WIDTH-1:0] phRamAddress,
  output logic [DATA_WIDTH-1:0] phRamOut,
  output logic                  phReadReq,
  output logic                  phWriteReq,
  input  logic [DATA_WIDTH-1:0] phRamIn
`ifdef TLB_STATS_EN
  ,
  output logic [31:0]           tlbHitCount,
  output logic [31:0]           tlbMissCount
`endif
);

  localparam int VPN_W  = ADDR_WIDTH - PAGE_BITS;
  localparam int IDX_W  = $clog2(TLB_ENTRIES);
  localparam int NCHUNK = (VPN_W + IDX_W - 1) / IDX_W;
  localparam int CNT_W  = $clog2(PH_LATENCY + 1);

  typedef enum logic [2:0] {READY, PRAM_WAIT, PT_WAIT0, PT_WAIT1, FAULT} state_t;

  // XOR-fold the VPN into IDX_W-bit chunks; the short top chunk is zero-extended.
  function automatic logic [IDX_W-1:0] tlb_index(input logic [VPN_W-1:0] vpn);
    logic [IDX_W*NCHUNK-1:0] ext;
    logic [IDX_W-1:0]        idx;
    ext = (IDX_W*NCHUNK)'(vpn);
    idx = '0;
    for (int unsigned c = 0; c < NCHUNK; c++)
      idx = idx ^ IDX_W'(ext >> (c * IDX_W));
    return idx;
  endfunction

  function automatic logic [1:0] prot_code(input logic np, input logic nx, input logic ro,
                                           input logic ex, input logic wr);
    if (np)       return 2'd1;
    if (nx && ex) return 2'd2;
    if (ro && wr) return 2'd3;
    return 2'd0;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_wr_q, req_wr_d, req_ex_q, req_ex_d;
  logic [VPN_W-1:0]        req_vpn_q, req_vpn_d;
  logic [PAGE_BITS-1:0]    req_off_q, req_off_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic [ADDR_WIDTH-1:0]   pte_addr_q, pte_addr_d;
  logic                    pte_np_q, pte_np_d, pte_nx_q, pte_nx_d, pte_ro_q, pte_ro_d;

  logic [DATA_WIDTH-1:0]   mcRamOut_d, phRamOut_d;
  logic [1:0]              mcStatus_d, mcFault_d;
  logic [ADDR_WIDTH-1:0]   phRamAddress_d;
  logic                    phReadReq_d, phWriteReq_d;

  logic [TLB_ENTRIES-1:0]  tlb_valid;
  logic                    tlb_np  [TLB_ENTRIES];
  logic                    tlb_nx  [TLB_ENTRIES];
  logic                    tlb_ro  [TLB_ENTRIES];
  logic [VPN_W-1:0]        tlb_tag [TLB_ENTRIES];
  logic [VPN_W-1:0]        tlb_pfn [TLB_ENTRIES];

  logic [VPN_W-1:0]        in_vpn, walk_pfn;
  logic [PAGE_BITS-1:0]    in_off;
  logic [IDX_W-1:0]        in_idx, wr_idx;
  logic                    in_hit, tlb_we;
  logic [1:0]              code;
  logic                    iss, iss_wr;
  logic [ADDR_WIDTH-1:0]   iss_addr;
  logic [DATA_WIDTH-1:0]   iss_data;

  assign in_vpn = mcRamAddress[ADDR_WIDTH-1:PAGE_BITS];
  assign in_off = mcRamAddress[PAGE_BITS-1:0];
  assign in_idx = tlb_index(in_vpn);
  assign wr_idx = tlb_index(req_vpn_q);
  assign in_hit = tlb_valid[in_idx] && (tlb_tag[in_idx] == in_vpn);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_wr_d       = req_wr_q;
    req_ex_d       = req_ex_q;
    req_vpn_d      = req_vpn_q;
    req_off_d      = req_off_q;
    req_wdata_d    = req_wdata_q;
    pte_addr_d     = pte_addr_q;
    pte_np_d       = pte_np_q;
    pte_nx_d       = pte_nx_q;
    pte_ro_d       = pte_ro_q;
    mcRamOut_d     = mcRamOut;
    mcStatus_d     = 2'd1;
    mcFault_d      = mcFault;
    phRamAddress_d = phRamAddress;
    phRamOut_d     = phRamOut;
    phReadReq_d    = 1'b0;
    phWriteReq_d   = 1'b0;
    tlb_we         = 1'b0;
    walk_pfn       = VPN_W'(phRamIn);
    code           = 2'd0;
    iss            = 1'b0;
    iss_wr         = 1'b0;
    iss_addr       = '0;
    iss_data       = '0;

    unique case (state_q)
      READY: begin
        if (mcReadReq || mcWriteReq) begin
          req_wr_d    = !mcReadReq;
          req_ex_d    = mcExecMode;
          req_vpn_d   = in_vpn;
          req_off_d   = in_off;
          req_wdata_d = mcRamIn;
          mcFault_d   = 2'd0;
          if (!mcAddrVirtual) begin
            iss      = 1'b1;
            iss_addr = mcRamAddress;
            iss_wr   = !mcReadReq;
            iss_data = mcRamIn;
          end else if (in_hit) begin
            code = prot_code(tlb_np[in_idx], tlb_nx[in_idx], tlb_ro[in_idx], mcExecMode, !mcReadReq);
            if (code != 2'd0) begin
              mcFault_d  = code;
              mcStatus_d = 2'd0;
              state_d    = FAULT;
            end else begin
              iss      = 1'b1;
              iss_addr = {tlb_pfn[in_idx], in_off};
              iss_wr   = !mcReadReq;
              iss_data = mcRamIn;
            end
          end else begin
            pte_addr_d     = ptAddress + ADDR_WIDTH'({in_vpn, 3'b000});
            phRamAddress_d = pte_addr_d;
            phReadReq_d    = 1'b1;
            cnt_d          = CNT_W'(1);
            state_d        = PT_WAIT0;
          end
        end
      end
      PRAM_WAIT: begin
        if (cnt_q == CNT_W'(PH_LATENCY)) begin
          if (!req_wr_q) mcRamOut_d = phRamIn;
          mcStatus_d = 2'd2;
          state_d    = READY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PT_WAIT0: begin
        if (cnt_q == CNT_W'(PH_LATENCY)) begin
          pte_np_d       = phRamIn[DATA_WIDTH-1];
          pte_nx_d       = phRamIn[DATA_WIDTH-2];
          pte_ro_d       = phRamIn[DATA_WIDTH-3];
          phRamAddress_d = pte_addr_q + ADDR_WIDTH'(4);
          phReadReq_d    = 1'b1;
          cnt_d          = CNT_W'(1);
          state_d        = PT_WAIT1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PT_WAIT1: begin
        if (cnt_q == CNT_W'(PH_LATENCY)) begin
          // The entry is installed even when the access then faults.
          tlb_we = 1'b1;
          code   = prot_code(pte_np_q, pte_nx_q, pte_ro_q, req_ex_q, req_wr_q);
          if (code != 2'd0) begin
            mcFault_d  = code;
            mcStatus_d = 2'd0;
            state_d    = FAULT;
          end else begin
            iss      = 1'b1;
            iss_addr = {walk_pfn, req_off_q};
            iss_wr   = req_wr_q;
            iss_data = req_wdata_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FAULT:   state_d = READY;
      default: state_d = READY;
    endcase

    if (iss) begin
      phRamAddress_d = iss_addr;
      phReadReq_d    = !iss_wr;
      phWriteReq_d   = iss_wr;
      if (iss_wr) phRamOut_d = iss_data;
      cnt_d          = CNT_W'(1);
      state_d        = PRAM_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= READY;
      cnt_q        <= '0;
      req_wr_q     <= 1'b0;
      req_ex_q     <= 1'b0;
      req_vpn_q    <= '0;
      req_off_q    <= '0;
      req_wdata_q  <= '0;
      pte_addr_q   <= '0;
      pte_np_q     <= 1'b0;
      pte_nx_q     <= 1'b0;
      pte_ro_q     <= 1'b0;
      mcRamOut     <= '0;
      mcStatus     <= 2'd1;
      mcFault      <= 2'd0;
      phRamAddress <= '0;
      phRamOut     <= '0;
      phReadReq    <= 1'b0;
      phWriteReq   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_wr_q     <= req_wr_d;
      req_ex_q     <= req_ex_d;
      req_vpn_q    <= req_vpn_d;
      req_off_q    <= req_off_d;
      req_wdata_q  <= req_wdata_d;
      pte_addr_q   <= pte_addr_d;
      pte_np_q     <= pte_np_d;
      pte_nx_q     <= pte_nx_d;
      pte_ro_q     <= pte_ro_d;
      mcRamOut     <= mcRamOut_d;
      mcStatus     <= mcStatus_d;
      mcFault      <= mcFault_d;
      phRamAddress <= phRamAddress_d;
      phRamOut     <= phRamOut_d;
      phReadReq    <= phReadReq_d;
      phWriteReq   <= phWriteReq_d;
    end
  end

  // The walk's install is applied after the flush so a coinciding write stays valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tlb_valid <= '0;
    end else begin
      if (tlbFlush) tlb_valid <= '0;
      if (tlb_we)   tlb_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tlb_we) begin
      tlb_np[wr_idx]  <= pte_np_q;
      tlb_nx[wr_idx]  <= pte_nx_q;
      tlb_ro[wr_idx]  <= pte_ro_q;
      tlb_tag[wr_idx] <= req_vpn_q;
      tlb_pfn[wr_idx] <= walk_pfn;
    end
  end

`ifdef TLB_STATS_EN
  logic acc_virt;
  assign acc_virt = (state_q == READY) && (mcReadReq || mcWriteReq) && mcAddrVirtual;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tlbHitCount  <= '0;
      tlbMissCount <= '0;
    end else if (tlbFlush) begin
      tlbHitCount  <= '0;
      tlbMissCount <= '0;
    end else if (acc_virt) begin
      if (in_hit && (tlbHitCount != '1))   tlbHitCount  <= tlbHitCount + 32'd1;
      if (!in_hit && (tlbMissCount != '1)) tlbMissCount <= tlbMissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmu_memory_controller.sv
// Directed bench for mmu_memory_controller: physical accesses are scoreboarded against
// expectations queued at request time; responses are checked with immediate assertions.
module tb_mmu_memory_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mcReadReq, mcWriteReq, mcAddrVirtual, mcExecMode, tlbFlush;
  logic [31:0] mcRamAddress, mcRamIn, mcRamOut, ptAddress, phRamAddress, phRamOut;
  logic [31:0] phRamIn = '0;
  logic [1:0]  mcStatus, mcFault;
  logic        phReadReq, phWriteReq;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        obs_q[$];
  acc_t        mon_a;
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0;
  int          req_cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  mmu_memory_controller #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .PAGE_BITS(12), .TLB_ENTRIES(64), .PH_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .mcReadReq(mcReadReq), .mcWriteReq(mcWriteReq), .mcAddrVirtual(mcAddrVirtual),
    .mcExecMode(mcExecMode), .mcRamAddress(mcRamAddress), .mcRamIn(mcRamIn),
    .mcRamOut(mcRamOut), .mcStatus(mcStatus), .mcFault(mcFault), .tlbFlush(tlbFlush),
    .ptAddress(ptAddress), .phRamAddress(phRamAddress), .phRamOut(phRamOut),
    .phReadReq(phReadReq), .phWriteReq(phWriteReq), .phRamIn(phRamIn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical RAM: read data appears the cycle after the strobe and is held.
  always @(posedge clk) begin
    if (phReadReq) phRamIn <= mem.exists(phRamAddress) ? mem[phRamAddress] : 32'h0;
  end

  always @(negedge clk) begin
    if (phReadReq || phWriteReq) begin
      mon_a.wr   = phWriteReq;
      mon_a.addr = phRamAddress;
      mon_a.data = phRamOut;
      mon_a.cyc  = cyc;
      obs_q.push_back(mon_a);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic expect_acc(input bit wr, input logic [31:0] a, input logic [31:0] d);
    acc_t x;
    x.wr = wr; x.addr = a; x.data = d; x.cyc = 0;
    exp_q.push_back(x);
  endtask

  task automatic check_accs(input string tag);
    acc_t e, o;
    chk({tag, "_acc_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_acc_wr"}, 32'(o.wr), 32'(e.wr));
      chk({tag, "_acc_addr"}, o.addr, e.addr);
      if (e.wr) chk({tag, "_acc_data"}, o.data, e.data);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_req(input bit wr, input bit virt, input bit ex, input logic [31:0] a,
                        input logic [31:0] d, output logic [1:0] st, output int lat);
    @(negedge clk);
    mcReadReq = !wr; mcWriteReq = wr; mcAddrVirtual = virt; mcExecMode = ex;
    mcRamAddress = a; mcRamIn = d;
    req_cyc = cyc;
    st = 2'd1; lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        mcReadReq = 1'b0; mcWriteReq = 1'b0; mcExecMode = 1'b0;
        mcRamAddress = $urandom; mcRamIn = $urandom;
      end
      if (mcStatus != 2'd1) begin
        st = mcStatus; lat = i;
        break;
      end
    end
    chk("req_completes", 32'(lat != 0), 32'd1);
  endtask

  logic [1:0] st;
  int         lat;
  acc_t       first;

  initial begin
    reset = 1'b0; mcReadReq = 0; mcWriteReq = 0; mcAddrVirtual = 0; mcExecMode = 0;
    tlbFlush = 0; mcRamAddress = '0; mcRamIn = '0; ptAddress = 32'h8000;
    mem[32'h100]   = 32'hDEADBEEF;
    mem[32'h8018]  = 32'h0;        mem[32'h801C] = 32'h55;
    mem[32'h55ABC] = 32'h0BADF00D;
    mem[32'h8038]  = 32'h80000000; mem[32'h803C] = 32'h66;
    mem[32'h8048]  = 32'h20000000; mem[32'h804C] = 32'h77;
    mem[32'h77010] = 32'h12345678;
    mem[32'h8050]  = 32'h40000000; mem[32'h8054] = 32'h88;
    mem[32'h88AAA] = 32'hA5A5A5A5;
    mem[32'h8058]  = 32'hE0000000; mem[32'h805C] = 32'h44;
    mem[32'h8060]  = 32'h0;        mem[32'h8064] = 32'h99;
    mem[32'h99000] = 32'h99990000;

    repeat (3) @(negedge clk);
    chk("rst_status", 32'(mcStatus), 32'd1);
    chk("rst_fault", 32'(mcFault), 32'd0);
    chk("rst_rdata", mcRamOut, 32'h0);
    chk("rst_rdreq", 32'(phReadReq), 32'd0);
    chk("rst_wrreq", 32'(phWriteReq), 32'd0);
    chk("rst_phaddr", phRamAddress, 32'h0);
    reset = 1'b1;

    // Bypass read
    expect_acc(0, 32'h100, 32'h0);
    do_req(0, 0, 0, 32'h100, 32'h0, st, lat);
    chk("bypass_status", 32'(st), 32'd2);
    chk("bypass_latency", 32'(lat), 32'd3);
    chk("bypass_rdata", mcRamOut, 32'hDEADBEEF);
    check_accs("bypass");

    // Virtual write, TLB miss with walk
    expect_acc(0, 32'h8018, 32'h0);
    expect_acc(0, 32'h801C, 32'h0);
    expect_acc(1, 32'h55ABC, 32'hCAFEF00D);
    do_req(1, 1, 0, 32'h3ABC, 32'hCAFEF00D, st, lat);
    chk("vwrite_status", 32'(st), 32'd2);
    chk("vwrite_rdata_kept", mcRamOut, 32'hDEADBEEF);
    check_accs("vwrite");

    // Same page read hits
    expect_acc(0, 32'h55ABC, 32'h0);
    do_req(0, 1, 0, 32'h3ABC, 32'h0, st, lat);
    chk("hit_status", 32'(st), 32'd2);
    chk("hit_rdata", mcRamOut, 32'h0BADF00D);
    chk("hit_has_access", 32'(obs_q.size() > 0), 32'd1);
    if (obs_q.size() > 0) begin
      first = obs_q[0];
      chk("hit_issue_cycle", 32'(first.cyc - req_cyc), 32'd1);
    end
    check_accs("hit");

    // Not-present page: walk then fault, then fault again from the TLB
    expect_acc(0, 32'h8038, 32'h0);
    expect_acc(0, 32'h803C, 32'h0);
    do_req(0, 1, 0, 32'h7123, 32'h0, st, lat);
    chk("np_status", 32'(st), 32'd0);
    chk("np_fault", 32'(mcFault), 32'd1);
    @(negedge clk);
    chk("np_after_status", 32'(mcStatus), 32'd1);
    chk("np_fault_sticky", 32'(mcFault), 32'd1);
    check_accs("np_walk");
    do_req(0, 1, 0, 32'h7123, 32'h0, st, lat);
    chk("np_hit_status", 32'(st), 32'd0);
    chk("np_hit_fault", 32'(mcFault), 32'd1);
    chk("np_hit_latency", 32'(lat), 32'd1);
    check_accs("np_hit");

    // Read-only page: write faults, read succeeds
    expect_acc(0, 32'h8048, 32'h0);
    expect_acc(0, 32'h804C, 32'h0);
    do_req(1, 1, 0, 32'h9010, 32'h11111111, st, lat);
    chk("ro_wr_status", 32'(st), 32'd0);
    chk("ro_wr_fault", 32'(mcFault), 32'd3);
    check_accs("ro_wr");
    expect_acc(0, 32'h77010, 32'h0);
    do_req(0, 1, 0, 32'h9010, 32'h0, st, lat);
    chk("ro_rd_status", 32'(st), 32'd2);
    chk("ro_rd_data", mcRamOut, 32'h12345678);
    chk("ro_rd_fault_clr", 32'(mcFault), 32'd0);
    check_accs("ro_rd");

    // Flush forces a new walk
    @(negedge clk); tlbFlush = 1'b1;
    @(negedge clk); tlbFlush = 1'b0;
    expect_acc(0, 32'h8048, 32'h0);
    expect_acc(0, 32'h804C, 32'h0);
    expect_acc(0, 32'h77010, 32'h0);
    do_req(0, 1, 0, 32'h9010, 32'h0, st, lat);
    chk("flush_status", 32'(st), 32'd2);
    chk("flush_data", mcRamOut, 32'h12345678);
    check_accs("flush");

    // No-exec page: restricted mode faults, unrestricted read hits
    expect_acc(0, 32'h8050, 32'h0);
    expect_acc(0, 32'h8054, 32'h0);
    do_req(0, 1, 1, 32'hAAAA, 32'h0, st, lat);
    chk("nx_status", 32'(st), 32'd0);
    chk("nx_fault", 32'(mcFault), 32'd2);
    check_accs("nx");
    expect_acc(0, 32'h88AAA, 32'h0);
    do_req(0, 1, 0, 32'hAAAA, 32'h0, st, lat);
    chk("nx_ok_status", 32'(st), 32'd2);
    chk("nx_ok_data", mcRamOut, 32'hA5A5A5A5);
    check_accs("nx_ok");

    // Fault priority: NP beats NX and RO
    expect_acc(0, 32'h8058, 32'h0);
    expect_acc(0, 32'h805C, 32'h0);
    do_req(1, 1, 1, 32'hB000, 32'h0, st, lat);
    chk("prio_fault", 32'(mcFault), 32'd1);
    check_accs("prio");

    // Reset during the second page-table read
    @(negedge clk);
    mcReadReq = 1'b1; mcAddrVirtual = 1'b1; mcRamAddress = 32'hC000;
    @(negedge clk);
    mcReadReq = 1'b0;
    for (int i = 0; i < 20 && obs_q.size() < 2; i++) begin
      @(negedge clk);
      #2;
    end
    chk("midwalk_reached", 32'(obs_q.size()), 32'd2);
    reset = 1'b0;
    #1;
    chk("midwalk_rst_status", 32'(mcStatus), 32'd1);
    chk("midwalk_rst_rdreq", 32'(phReadReq), 32'd0);
    chk("midwalk_rst_phaddr", phRamAddress, 32'h0);
    chk("midwalk_rst_rdata", mcRamOut, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
    expect_acc(0, 32'h8060, 32'h0);
    expect_acc(0, 32'h8064, 32'h0);
    expect_acc(0, 32'h99000, 32'h0);
    do_req(0, 1, 0, 32'hC000, 32'h0, st, lat);
    chk("rewalk_status", 32'(st), 32'd2);
    chk("rewalk_data", mcRamOut, 32'h99990000);
    check_accs("rewalk");
    expect_acc(0, 32'h8018, 32'h0);
    expect_acc(0, 32'h801C, 32'h0);
    expect_acc(0, 32'h55ABC, 32'h0);
    do_req(0, 1, 0, 32'h3ABC, 32'h0, st, lat);
    chk("post_rst_data", mcRamOut, 32'h0BADF00D);
    check_accs("post_rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_memory_controller.md
Name: mmu_memory_controller

Overview:
Parametrised successor to the single-config memory controller. It accepts one read/write request at a time from the CPU side. Virtual addresses are translated through a direct-mapped TLB with a hardware two-word page-table walk on miss; physical addresses bypass translation. Adds:
- configurable widths and TLB depth
- TLB valid bits and flush
- read-only page protection
- explicit fault codes
- fixed physical-RAM latency

Parameters:
- DATA_WIDTH, 32, width of data and page-table words
- ADDR_WIDTH, 32, virtual and physical address width
- PAGE_BITS, 12, page offset bits; VPN/PFN width = ADDR_WIDTH-PAGE_BITS
- TLB_ENTRIES, 64, TLB depth; power of two, >=2
- PH_LATENCY, 2, cycles from request issue to phRamIn valid; >=1

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- mcReadReq  in  1  read request, sampled in READY only
- mcWriteReq  in  1  write request; if both asserted, read wins
- mcAddrVirtual  in  1  1 = translate mcRamAddress, 0 = physical bypass
- mcExecMode  in  1  requester is restricted (user) mode
- mcRamAddress  in  ADDR_WIDTH  request address
- mcRamIn  in  DATA_WIDTH  write data
- mcRamOut  out  DATA_WIDTH  read data, valid when mcStatus==2 after a read
- mcStatus  out  2  0 = fault (one cycle), 1 = busy/idle, 2 = done (one cycle)
- mcFault  out  2  0 none, 1 not-present, 2 exec-mode violation, 3 write to read-only
- tlbFlush  in  1  invalidate all TLB entries
- ptAddress  in  ADDR_WIDTH  page-table base (byte address)
- phRamAddress  out  ADDR_WIDTH  physical address
- phRamOut  out  DATA_WIDTH  physical write data
- phReadReq  out  1  physical read strobe, one cycle
- phWriteReq  out  1  physical write strobe, one cycle
- phRamIn  in  DATA_WIDTH  physical read data

Behaviour:
- Reset (async, reset=0):
  - state=READY
  - all outputs 0 except mcStatus=1
  - all TLB valid bits cleared
- States and transitions:
  - READY, PRAM_WAIT, PT_WAIT0, PT_WAIT1, FAULT.
  - READY with no request: hold; mcStatus=1.
  - READY, request with mcAddrVirtual=0: issue phRamAddress=mcRamAddress, one-cycle strobe; then PRAM_WAIT.
  - PRAM_WAIT: count PH_LATENCY cycles, then:
    - capture phRamIn into mcRamOut if the request was a read (mcRamOut unchanged on write);
    - mcStatus=2 for one cycle; back to READY.
  - Bypass request latency is PH_LATENCY+1 cycles from request to done.
- TLB index and entry:
  - Index = XOR-fold of VPN into log2(TLB_ENTRIES)-bit chunks; the top chunk is zero-extended.
  - Entry = {valid, NP, NX, RO, VPN tag, PFN}.
- TLB hit (valid && tag==VPN):
  - Check protection in priority order:
    - NP -> fault 1;
    - NX && mcExecMode -> fault 2;
    - RO && write -> fault 3.
  - Otherwise phRamAddress={PFN, offset}; proceed as the bypass path.
- TLB miss: read PTE word0 at ptAddress+VPN*8, then word1 at +4. Each read waits PH_LATENCY (PT_WAIT0, PT_WAIT1).
  - word0: bit31 NP, bit30 NX, bit29 RO.
  - word1[PFN-1:0] = PFN.
  - Write the TLB entry (valid=1) after word1 even if it faults, then apply the same protection checks.
  - The final access uses the saved request fields only; CPU inputs need not be held.
- FAULT:
  - mcStatus=0 with mcFault set for one cycle; no physical access is issued.
  - Then READY, mcStatus=1; mcFault stays until the next accepted request clears it.
- Arithmetic:
  - PTE address computed modulo 2^ADDR_WIDTH; wraps silently.
- Flush:
  - tlbFlush in any state clears valid bits the next edge.
  - A flush coinciding with the walk's TLB write leaves that entry valid (write wins); the in-flight access completes.
- Requests outside READY are ignored; there is no queueing.
- A conflicting index simply overwrites the entry (no associativity).

Optional Feature:
TLB_STATS_EN adds outputs tlbHitCount and tlbMissCount (32 bits each).
- Each increments once per accepted virtual request: hit or miss.
- Saturates at all-ones; cleared by reset and by tlbFlush.
- Without the macro the ports and counters do not exist.

Test Plan:
- Bypass read, addr 0x100, phRamIn=0xDEADBEEF, PH_LATENCY=2 -> one phReadReq pulse; done (mcStatus=2) 3 cycles later; mcRamOut=0xDEADBEEF.
- Virtual write 0x00003ABC, ptAddress=0x8000, PTE word0=0, word1=0x55 -> reads at 0x8018 then 0x801C; write at 0x00055ABC with mcRamIn data.
- Repeat read of the same page -> no PTE reads; physical access within 1 cycle of request (hit).
- PTE word0=0x80000000 -> mcStatus=0, mcFault=1, no data access; re-access hits TLB and faults again without a walk.
- Write to a page with RO=1 -> mcFault=3; read of the same page succeeds. tlbFlush then re-read -> walk occurs again.
- Assert reset mid-walk (PT_WAIT1) -> outputs reset immediately; next request walks from scratch.
